// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl
//
// Sequencing controller for a bank of N level-sensitive D-latches, each W bits wide, with
// active-high asynchronous reset. It accepts write and clear-all requests over valid/ready
// handshakes. It drives the shared data bus and the per-entry enables and resets. Every enable
// pulse has one setup cycle before it and HOLD_CYC hold cycles after it, so D is stable while
// any E is high.
//
// Optional feature macro: LATCH_BANK_CTRL_INIT_CLEAR_EN
//   When defined, reset enters CLEAR. A full CLR_CYC clear then runs after release, with no
//   done pulse.
//
// Ports
//   C         in   clock, rising edge
//   R         in   asynchronous active-low reset
//   req_v     in   write request valid
//   req_rdy   out  write request ready (IDLE only)
//   req_addr  in   target entry, AW bits
//   req_data  in   data to store, W bits
//   clr_v     in   clear-all request valid (wins over req_v)
//   clr_rdy   out  clear request ready (IDLE only)
//   lat_D     out  shared latch data bus
//   lat_E     out  one-hot latch enables
//   lat_R     out  latch resets
//   busy      out  high outside IDLE
//   done      out  pulse on the last cycle of an operation
//   err       out  pulse with done when the write address was >= N
//
// All outputs are registered. Each one is computed from the next state, so the value seen in
// a cycle belongs to the state of that cycle.
module latch_bank_ctrl #(
  parameter int unsigned N        = 8,
  parameter int unsigned W        = 4,
  parameter int unsigned HOLD_CYC = 1,
  parameter int unsigned CLR_CYC  = 2,
  localparam int unsigned AW      = $clog2(N)
) (
  input  logic          C,
  input  logic          R,
  input  logic          req_v,
  output logic          req_rdy,
  input  logic [AW-1:0] req_addr,
  input  logic [W-1:0]  req_data,
  input  logic          clr_v,
  output logic          clr_rdy,
  output logic [W-1:0]  lat_D,
  output logic [N-1:0]  lat_E,
  output logic [N-1:0]  lat_R,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StClear} state_e;

`ifdef LATCH_BANK_CTRL_INIT_CLEAR_EN
  localparam state_e ResetState = StClear;
  localparam bit     InitClear  = 1'b1;
`else
  localparam state_e ResetState = StIdle;
  localparam bit     InitClear  = 1'b0;
`endif

  localparam int unsigned CntMax = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
  localparam int unsigned CW     = $clog2(CntMax + 1);
  localparam logic [CW-1:0] HoldLast = CW'(HOLD_CYC);
  localparam logic [CW-1:0] ClrLast  = CW'(CLR_CYC);
  localparam logic [CW-1:0] CntOne   = CW'(1);

  state_e         state_q;
  logic [CW-1:0]  cnt_q;      // 1-based cycle index within HOLD / CLEAR
  logic [AW-1:0]  addr_q;
  logic           bad_q;      // latched write address was out of range
  logic           quiet_q;    // suppress done for the power-on clear
  logic           rdy_q;
  logic [W-1:0]   lat_d_q;
  logic [N-1:0]   lat_e_q;
  logic [N-1:0]   lat_r_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;

  logic [N-1:0]   sel_oh;
  logic           req_bad;

  always_comb begin
    sel_oh = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel_oh[i] = (32'(addr_q) == i);
    end
  end

  assign req_bad = (32'(req_addr) >= N);

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      addr_q  <= '0;
      bad_q   <= 1'b0;
      quiet_q <= InitClear;
      rdy_q   <= 1'b0;
      lat_d_q <= '0;
      lat_e_q <= '0;
      lat_r_q <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      lat_e_q <= '0;
      lat_r_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
      unique case (state_q)
        StIdle: begin
          // rdy_q is low in IDLE only on the first cycle after reset release
          if (rdy_q && clr_v) begin
            state_q <= StClear;
            cnt_q   <= CntOne;
            lat_r_q <= '1;
            done_q  <= (ClrLast == CntOne);
          end else if (rdy_q && req_v) begin
            state_q <= StSetup;
            addr_q  <= req_addr;
            bad_q   <= req_bad;
            lat_d_q <= req_data;
          end else begin
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        StSetup: begin
          state_q <= StPulse;
          lat_e_q <= bad_q ? '0 : sel_oh;
        end
        StPulse: begin
          state_q <= StHold;
          cnt_q   <= CntOne;
          done_q  <= (HoldLast == CntOne);
          err_q   <= (HoldLast == CntOne) && bad_q;
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CntOne;
            done_q  <= ((cnt_q + CntOne) == HoldLast);
            err_q   <= ((cnt_q + CntOne) == HoldLast) && bad_q;
          end
        end
        StClear: begin
          // The power-on clear starts with cnt_q = 0, so it also gets CLR_CYC cycles
          if (cnt_q == ClrLast) begin
            state_q <= StIdle;
            quiet_q <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CntOne;
            lat_r_q <= '1;
            done_q  <= ((cnt_q + CntOne) == ClrLast) && !quiet_q;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_rdy = rdy_q;
  assign clr_rdy = rdy_q;
  assign lat_D   = lat_d_q;
  assign lat_E   = lat_e_q;
  assign lat_R   = lat_r_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Self-checking bench for latch_bank_ctrl. N = 10, so addresses 10..15 are out of range.
// Expected outputs come from per-operation timelines that follow the handshake timing rules.
module tb_latch_bank_ctrl;

  localparam int unsigned N    = 10;
  localparam int unsigned W    = 4;
  localparam int unsigned HOLD = 1;
  localparam int unsigned CLR  = 2;
  localparam int unsigned AW   = $clog2(N);
  localparam int unsigned EW   = 5 + W + 2 * N;

  typedef logic [EW-1:0] vec_t;

  logic          C;
  logic          R;
  logic          req_v;
  logic          req_rdy;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_data;
  logic          clr_v;
  logic          clr_rdy;
  logic [W-1:0]  lat_D;
  logic [N-1:0]  lat_E;
  logic [N-1:0]  lat_R;
  logic          busy;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] cur_d = '0;

  vec_t obs;
  vec_t want;
  assign obs = {req_rdy, clr_rdy, busy, done, err, lat_D, lat_E, lat_R};

  latch_bank_ctrl #(
    .N(N), .W(W), .HOLD_CYC(HOLD), .CLR_CYC(CLR)
  ) dut (
    .C(C), .R(R),
    .req_v(req_v), .req_rdy(req_rdy), .req_addr(req_addr), .req_data(req_data),
    .clr_v(clr_v), .clr_rdy(clr_rdy),
    .lat_D(lat_D), .lat_E(lat_E), .lat_R(lat_R),
    .busy(busy), .done(done), .err(err)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Expected-output model

  function automatic vec_t pack(bit rdy, bit bsy, bit dn, bit er, logic [W-1:0] d,
                                logic [N-1:0] e, logic [N-1:0] r);
    return {rdy, rdy, bsy, dn, er, d, e, r};
  endfunction

  function automatic vec_t exp_reset();
    return pack(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '1);
  endfunction

  function automatic vec_t exp_idle(logic [W-1:0] d);
    return pack(1'b1, 1'b0, 1'b0, 1'b0, d, '0, '0);
  endfunction

  // Cycle c after the accepting edge of a write. c = 3+HOLD is the IDLE cycle after it.
  function automatic vec_t exp_write(int addr, logic [W-1:0] d, int c);
    bit bad;
    logic [N-1:0] e;
    bad = (addr >= int'(N));
    e = '0;
    if (c == 1) return pack(1'b0, 1'b1, 1'b0, 1'b0, d, '0, '0);
    if (c == 2) begin
      if (!bad) e[addr] = 1'b1;
      return pack(1'b0, 1'b1, 1'b0, 1'b0, d, e, '0);
    end
    if (c <= 2 + int'(HOLD))
      return pack(1'b0, 1'b1, c == 2 + int'(HOLD), (c == 2 + int'(HOLD)) && bad, d, '0, '0);
    return exp_idle(d);
  endfunction

  function automatic vec_t exp_clear(logic [W-1:0] d, int c);
    if (c <= int'(CLR)) return pack(1'b0, 1'b1, c == int'(CLR), 1'b0, d, '0, '1);
    return exp_idle(d);
  endfunction

  // Cycle c after the first rising edge following reset release
  function automatic vec_t exp_release(int c);
`ifdef LATCH_BANK_CTRL_INIT_CLEAR_EN
    if (c <= int'(CLR)) return pack(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '1);
`endif
    return exp_idle('0);
  endfunction

  // Scenarios

  task automatic test_reset();
    R = 1'b0; req_v = 1'b0; clr_v = 1'b0; req_addr = '0; req_data = '0;
    repeat (3) @(negedge C);
    want = exp_reset();
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL reset_hold got=%h want=%h", obs, want);
    end
    R = 1'b1;
    #1;
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL reset_release_pre_edge got=%h want=%h", obs, want);
    end
    for (int c = 1; c <= int'(CLR) + 1; c++) begin
      @(negedge C);
      want = exp_release(c);
      checks++;
      if (obs !== want) begin
        errors++; $display("FAIL reset_release c=%0d got=%h want=%h", c, obs, want);
      end
    end
    cur_d = '0;
  endtask

  task automatic test_single_write();
    req_v = 1'b1; req_addr = AW'(5); req_data = 4'hA;
    @(posedge C);
    for (int c = 1; c <= 3 + int'(HOLD); c++) begin
      @(negedge C);
      if (c == 1) req_v = 1'b0;
      want = exp_write(5, 4'hA, c);
      checks++;
      if (obs !== want) begin
        errors++; $display("FAIL single_write c=%0d got=%h want=%h", c, obs, want);
      end
    end
    cur_d = 4'hA;
  endtask

  task automatic test_clear_priority();
    clr_v = 1'b1; req_v = 1'b1; req_addr = AW'(3); req_data = 4'h6;
    @(posedge C);
    for (int c = 1; c <= int'(CLR) + 1; c++) begin
      @(negedge C);
      if (c == 1) clr_v = 1'b0;
      want = exp_clear(cur_d, c);
      checks++;
      if (obs !== want) begin
        errors++; $display("FAIL clear_priority c=%0d got=%h want=%h", c, obs, want);
      end
    end
    // req_v was held throughout; it is accepted at the next edge
    @(posedge C);
    for (int c = 1; c <= 3 + int'(HOLD); c++) begin
      @(negedge C);
      if (c == 1) req_v = 1'b0;
      want = exp_write(3, 4'h6, c);
      checks++;
      if (obs !== want) begin
        errors++; $display("FAIL clear_then_write c=%0d got=%h want=%h", c, obs, want);
      end
    end
    cur_d = 4'h6;
  endtask

  task automatic test_out_of_range();
    int addrs[2] = '{12, 15};
    for (int i = 0; i < 2; i++) begin
      req_v = 1'b1; req_addr = AW'(addrs[i]); req_data = 4'h3 + 4'(i);
      @(posedge C);
      for (int c = 1; c <= 3 + int'(HOLD); c++) begin
        @(negedge C);
        if (c == 1) req_v = 1'b0;
        want = exp_write(addrs[i], 4'h3 + 4'(i), c);
        checks++;
        if (obs !== want) begin
          errors++;
          $display("FAIL out_of_range a=%0d c=%0d got=%h want=%h", addrs[i], c, obs, want);
        end
      end
      cur_d = 4'h3 + 4'(i);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] dat[3] = '{4'h1, 4'hE, 4'h7};
    req_v = 1'b1; req_addr = AW'(0); req_data = dat[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge C);
      for (int c = 1; c <= 3 + int'(HOLD); c++) begin
        @(negedge C);
        if (c == 1) begin
          if (i < 2) begin
            req_addr = AW'(i + 1); req_data = dat[i+1];
          end else begin
            req_v = 1'b0;
          end
        end
        want = exp_write(i, dat[i], c);
        checks++;
        if (obs !== want) begin
          errors++; $display("FAIL back_to_back w=%0d c=%0d got=%h want=%h", i, c, obs, want);
        end
      end
    end
    cur_d = dat[2];
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge C);
        want = exp_idle(cur_d);
        checks++;
        if (obs !== want) begin
          errors++; $display("FAIL random_idle n=%0d got=%h want=%h", n, obs, want);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        clr_v = 1'b1; req_v = 1'($urandom_range(0, 1));
        req_addr = AW'($urandom_range(0, 15)); req_data = W'($urandom);
        @(posedge C);
        for (int c = 1; c <= int'(CLR) + 1; c++) begin
          @(negedge C);
          if (c == 1) begin
            clr_v = 1'b0; req_v = 1'b0;
          end
          want = exp_clear(cur_d, c);
          checks++;
          if (obs !== want) begin
            errors++; $display("FAIL random_clear n=%0d c=%0d got=%h want=%h", n, c, obs, want);
          end
        end
      end else begin
        int a;
        logic [W-1:0] d;
        a = int'($urandom_range(0, 15));
        d = W'($urandom);
        req_v = 1'b1; req_addr = AW'(a); req_data = d;
        @(posedge C);
        for (int c = 1; c <= 3 + int'(HOLD); c++) begin
          @(negedge C);
          if (c == 1) req_v = 1'b0;
          want = exp_write(a, d, c);
          checks++;
          if (obs !== want) begin
            errors++;
            $display("FAIL random_write n=%0d a=%0d c=%0d got=%h want=%h", n, a, c, obs, want);
          end
        end
        cur_d = d;
      end
    end
  endtask

  task automatic test_reset_mid();
    req_v = 1'b1; req_addr = AW'(4); req_data = 4'h9;
    @(posedge C);
    for (int c = 1; c <= 2; c++) begin
      @(negedge C);
      if (c == 1) req_v = 1'b0;
      want = exp_write(4, 4'h9, c);
      checks++;
      if (obs !== want) begin
        errors++; $display("FAIL reset_mid_pre c=%0d got=%h want=%h", c, obs, want);
      end
    end
    // In PULSE: reset must clear lat_E and raise lat_R without waiting for a clock edge
    #1 R = 1'b0;
    #1;
    want = exp_reset();
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL reset_mid_async got=%h want=%h", obs, want);
    end
    @(posedge C);
    @(negedge C);
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL reset_mid_held got=%h want=%h", obs, want);
    end
    R = 1'b1;
    for (int c = 1; c <= int'(CLR) + 2; c++) begin
      @(negedge C);
      want = exp_release(c);
      checks++;
      if (obs !== want) begin
        errors++; $display("FAIL reset_mid_release c=%0d got=%h want=%h", c, obs, want);
      end
    end
    cur_d = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_clear_priority();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_single_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
